// File: rtl/exp_rom_arb_pkg.sv
// Shared constants and helpers for the exp-coefficient ROM arbiter.
//   EXP_ROM_DWIDTH / EXP_ROM_AWIDTH / EXP_ROM_DEPTH : default ROM geometry (32 x 8)
//   MAX_REQ / IDX_W : upper bound on requesters and the matching index width
//   onehot_to_idx   : encodes a one-hot grant vector into a requester index
package exp_rom_arb_pkg;

  localparam int unsigned EXP_ROM_DWIDTH = 8;
  localparam int unsigned EXP_ROM_AWIDTH = 5;
  localparam int unsigned EXP_ROM_DEPTH  = 32;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  // OR-encoding is exact for one-hot input and yields 0 for an all-zero vector.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/exp_rom_rr_arbiter.sv
// Grant logic for the exp ROM arbiter.
// Default build: round-robin starting at ptr, with wrap-around.
// EXP_ROM_ARB_FIXED_PRIO_EN defined: fixed priority (lowest index wins), no ptr register.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   req        : per-requester request vector
//   grant      : combinational one-hot grant (all-zero when req is zero)
module exp_rom_rr_arbiter
  import exp_rom_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant
);

`ifdef EXP_ROM_ARB_FIXED_PRIO_EN

  // Clock and reset are only needed by the rotating pointer.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ reset;

  // Isolate the lowest set bit.
  always_comb begin
    grant = req & (~req + NUM_REQ'(1));
  end

`else

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   ptr;
  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] masked;
  logic [IDX_W-1:0]   gidx;

  // Prefer requests at or above ptr; fall back to the lowest request (wrap-around).
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      mask[i] = (PTR_W'(i) >= ptr);
    end
    masked = req & mask;
    if (|masked) grant = masked & (~masked + NUM_REQ'(1));
    else         grant = req & (~req + NUM_REQ'(1));
    gidx = onehot_to_idx(MAX_REQ'(grant));
  end

  // Pointer moves one past the winner; holds when nothing is granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (|grant) begin
      if (gidx == IDX_W'(NUM_REQ - 1)) ptr <= '0;
      else                             ptr <= PTR_W'(gidx + IDX_W'(1));
    end
  end

`endif

endmodule

// File: rtl/exp_rom_arbiter.sv
// Shares the single-port exp-coefficient ROM between NUM_REQ requesters.
// One grant per cycle; response returns two cycles after the handshake.
// Build option: EXP_ROM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
// Ports:
//   clk, reset   : clock and asynchronous active-high reset
//   req_valid    : per-requester request
//   req_addr     : packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_ready    : combinational one-hot grant (forced low during reset)
//   rsp_valid    : one-hot response strobe
//   rsp_data     : registered ROM word, broadcast
//   rom_address0 : ROM address, rom_ce0 : ROM enable, rom_q0 : ROM data (1-cycle latency)
module exp_rom_arbiter
  import exp_rom_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = EXP_ROM_DWIDTH,
  parameter int unsigned ADDR_WIDTH = EXP_ROM_AWIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [ADDR_WIDTH-1:0]         rom_address0,
  output logic                          rom_ce0,
  input  logic [DATA_WIDTH-1:0]         rom_q0
);

  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] g1;
  logic [IDX_W-1:0]   gidx;

  exp_rom_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req_valid),
    .grant (grant)
  );

  // Grant and ROM drive; reset overrides the combinational grant.
  always_comb begin
    req_ready    = reset ? '0 : grant;
    rom_ce0      = !reset && (|req_valid);
    gidx         = onehot_to_idx(MAX_REQ'(req_ready));
    rom_address0 = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if ((|req_ready) && (gidx == IDX_W'(i))) begin
        rom_address0 = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Stage 1 tracks the grant across the ROM read; stage 2 returns the word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      g1        <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      g1        <= req_ready;
      rsp_valid <= g1;
      if (|g1) rsp_data <= rom_q0;
    end
  end

endmodule
